// File: rtl/freq_est_if.sv
// Measurement request/result bundle for freq_est: control inputs, the sampled square wave, and the estimate strobe.
interface freq_est_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic             continuous;
  logic             sig_in;
  logic [WIDTH-1:0] phase_inc_est;
  logic             est_valid;
  logic             busy;

  modport master (
    output start, continuous, sig_in,
    input  phase_inc_est, est_valid, busy
  );

  modport slave (
    input  start, continuous, sig_in,
    output phase_inc_est, est_valid, busy
  );
endinterface

// File: rtl/freq_est.sv
// Gated edge counter: counts rising edges of sig_in over 2^GATE_LOG2 cycles and reports a phase increment.
// Optional FREQ_EST_SYNC_EN adds a two-flop input synchronizer in front of the edge detector.
module freq_est #(
  parameter int WIDTH     = 64,
  parameter int GATE_LOG2 = 16
) (
  input  logic         clk,
  input  logic         rst,
  freq_est_if.slave    bus,
  output logic [1:0]   dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [GATE_LOG2-1:0] GATE_LAST = '1;

  state_e               state_q, state_d;
  logic [GATE_LOG2-1:0] edge_cnt_q, edge_cnt_d;
  logic [GATE_LOG2-1:0] gate_cnt_q, gate_cnt_d;
  logic [WIDTH-1:0]     est_q, est_d;
  logic                 valid_q, valid_d;
  logic                 sig_d_q;
  logic                 sig_s;
  logic                 rise;

`ifdef FREQ_EST_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], bus.sig_in};
    end
  end

  assign sig_s = sync_q[1];
`else
  assign sig_s = bus.sig_in;
`endif

  assign rise = sig_s & ~sig_d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      edge_cnt_q <= '0;
      gate_cnt_q <= '0;
      est_q      <= '0;
      valid_q    <= 1'b0;
      sig_d_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      gate_cnt_q <= gate_cnt_d;
      est_q      <= est_d;
      valid_q    <= valid_d;
      sig_d_q    <= sig_s;
    end
  end

  // Start is only honoured in IDLE; COUNT spans exactly N cycles and DONE one more.
  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    gate_cnt_d = gate_cnt_q;
    est_d      = est_q;
    valid_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          edge_cnt_d = '0;
          gate_cnt_d = '0;
          state_d    = S_COUNT;
        end
      end
      S_COUNT: begin
        gate_cnt_d = gate_cnt_q + 1'b1;
        if (rise) begin
          edge_cnt_d = edge_cnt_q + 1'b1;
        end
        if (gate_cnt_q == GATE_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        est_d   = {edge_cnt_q, {(WIDTH-GATE_LOG2){1'b0}}};
        valid_d = 1'b1;
        if (bus.continuous) begin
          edge_cnt_d = '0;
          gate_cnt_d = '0;
          state_d    = S_COUNT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // est_valid is a one-cycle strobe with no back-pressure; phase_inc_est holds until the next strobe.
  assign bus.phase_inc_est = est_q;
  assign bus.est_valid     = valid_q;
  assign bus.busy          = (state_q != S_IDLE);
  assign dbg_state_o       = state_q;

endmodule
